// File: rtl/fifo_pkg.sv
// Shared helpers for the word packer: width/depth legality checks, count width,
// and default-configuration types.
package fifo_pkg;

    function automatic int multiple(input int out_w, input int in_w);
        return out_w / in_w;
    endfunction

    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Output width must be the input width times a power of two of at least 2.
    function automatic bit widths_ok(input int in_w, input int out_w);
        return (in_w > 0) && (out_w % in_w == 0) &&
               (multiple(out_w, in_w) >= 2) && is_pow2(multiple(out_w, in_w));
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && is_pow2(depth);
    endfunction

    localparam int DEF_IN_WIDTH  = 32;
    localparam int DEF_OUT_WIDTH = 64;
    localparam int DEF_OUT_DEPTH = 4;
    localparam int DEF_MULTIPLE  = multiple(DEF_OUT_WIDTH, DEF_IN_WIDTH);
    localparam int DEF_CNT_W     = count_w(DEF_OUT_DEPTH);

    typedef logic [DEF_MULTIPLE-1:0] keep_t;

endpackage

// File: rtl/fifo_word_buf.sv
// Synchronous register FIFO with first-word-fall-through head; count is the
// single source of truth for full/empty, pointers simply wrap.
module fifo_word_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4,
    parameter int CNT_W = count_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && (count < CNT_W'(DEPTH));
    assign do_pop    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: storage is cleared on reset so the head reads zero afterwards.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs IN_WIDTH slices MSB-first into OUT_WIDTH words and buffers them (FWFT).
// Define PACKER_FLUSH_EN to let in_last commit a partial word early.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter  int IN_WIDTH  = 32,
    parameter  int OUT_WIDTH = 64,
    parameter  int OUT_DEPTH = 4,
    localparam int MULTIPLE  = multiple(OUT_WIDTH, IN_WIDTH),
    localparam int CNT_W     = count_w(OUT_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [MULTIPLE-1:0]  out_keep,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     out_count
);

    localparam int SEL_W = $clog2(MULTIPLE);

    if (!widths_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_widths
        $error("fifo_word_packer: OUT_WIDTH must be IN_WIDTH * 2^n, n >= 1");
    end
    if (!depth_ok(OUT_DEPTH)) begin : g_bad_depth
        $error("fifo_word_packer: OUT_DEPTH must be a power of 2, >= 2");
    end

    logic [SEL_W-1:0]     sel;
    logic [SEL_W-1:0]     slot;
    logic [OUT_WIDTH-1:0] acc;
    logic [MULTIPLE-1:0]  keep;
    logic [OUT_WIDTH-1:0] beat_word;
    logic [MULTIPLE-1:0]  beat_keep;
    logic                 accept;
    logic                 flush;
    logic                 commit;
    logic [OUT_WIDTH-1:0] head_data;
    logic [MULTIPLE-1:0]  head_keep;

`ifdef PACKER_FLUSH_EN
    assign flush = in_last;
`else
    logic unused_in_last;
    assign flush          = 1'b0;
    assign unused_in_last = in_last;
`endif

    // First slice of a word lands in the most significant position.
    assign slot   = SEL_W'(MULTIPLE - 1) - sel;
    assign accept = in_valid && in_ready;
    assign commit = accept && ((sel == SEL_W'(MULTIPLE - 1)) || flush);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        beat_word = '0;
        beat_keep = '0;
        beat_word[int'(slot)*IN_WIDTH +: IN_WIDTH] = in_data;
        beat_keep[slot] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel  <= '0;
            acc  <= '0;
            keep <= '0;
        end else if (accept) begin
            if (commit) begin
                sel  <= '0;
                acc  <= '0;
                keep <= '0;
            end else begin
                sel  <= sel + SEL_W'(1);
                acc  <= acc | beat_word;
                keep <= keep | beat_keep;
            end
        end
    end

    fifo_word_buf #(
        .WIDTH (MULTIPLE + OUT_WIDTH),
        .DEPTH (OUT_DEPTH),
        .CNT_W (CNT_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (commit),
        .push_data ({keep | beat_keep, acc | beat_word}),
        .pop       (out_ready),
        .head_data ({head_keep, head_data}),
        .count     (out_count)
    );

    // in_ready depends only on the registered count, never on out_ready.
    assign in_ready  = (out_count < CNT_W'(OUT_DEPTH));
    assign out_valid = (out_count != '0);
    assign out_data  = out_valid ? head_data : '0;
    assign out_keep  = out_valid ? head_keep : '0;

endmodule
